// File: rtl/executor_pkg.sv
// Shared types and helpers for the packet_executor program engine.
package executor_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_LI   = 4'h1,
    OP_LUI  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_ARG  = 4'hC,
    OP_BEQ  = 4'hD,
    OP_BNE  = 4'hE,
    OP_JMP  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [3:0] WIDTH_B = 4'd1;
  localparam logic [3:0] WIDTH_H = 4'd2;
  localparam logic [3:0] WIDTH_W = 4'd4;

  function automatic opcode_t ir_op(input logic [31:0] ir);
    return opcode_t'(ir[31:28]);
  endfunction

  function automatic logic [3:0] ir_rd(input logic [31:0] ir);
    return ir[27:24];
  endfunction

  function automatic logic [3:0] ir_rs(input logic [31:0] ir);
    return ir[23:20];
  endfunction

  function automatic logic [3:0] ir_rt(input logic [31:0] ir);
    return ir[19:16];
  endfunction

  function automatic logic [15:0] ir_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  // Unsupported width codes fall back to a full word access.
  function automatic logic [3:0] width_norm(input logic [3:0] code);
    case (code)
      WIDTH_B, WIDTH_H: return code;
      default:          return WIDTH_W;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for packet_executor: result and branch-taken flag.
module exec_alu
  import executor_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm,
  output logic [DATA_W-1:0] result,
  output logic              taken
);

  always_comb begin
    result = '0;
    taken  = 1'b0;
    case (opcode_t'(op))
      OP_LI:   result = DATA_W'(imm);
      OP_LUI:  result = DATA_W'({imm, 16'h0000});
      OP_ADD:  result = rs_val + rt_val;
      OP_SUB:  result = rs_val - rt_val;
      OP_AND:  result = rs_val & rt_val;
      OP_OR:   result = rs_val | rt_val;
      OP_XOR:  result = rs_val ^ rt_val;
      OP_SHL:  result = rs_val << imm[4:0];
      OP_SHR:  result = rs_val >> imm[4:0];
      OP_BEQ:  taken  = (rs_val == rt_val);
      OP_BNE:  taken  = (rs_val != rt_val);
      default: ;
    endcase
  end

endmodule

// File: rtl/packet_executor.sv
// In-order program executor: fetch/exec FSM, 16-entry register file, memory master.
// Define EXECUTOR_WATCHDOG_EN to stop runaway programs after 1024 instructions.
module packet_executor
  import executor_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] args_start_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              ready_o
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [16];

  opcode_t           op;
  logic [3:0]        rd, rs, rt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val;
  logic [DATA_W-1:0] alu_result;
  logic              taken;
  logic [ADDR_W-1:0] ld_st_addr, arg_addr, next_pc;
  logic [3:0]        acc_width;
  logic [DATA_W-1:0] byte_mask, wr_data;
  logic              wr_en;
  logic              wd_expire;

  assign op  = ir_op(ir);
  assign rd  = ir_rd(ir);
  assign rs  = ir_rs(ir);
  assign rt  = ir_rt(ir);
  assign imm = ir_imm(ir);

  assign rd_val = (rd == 4'd0) ? '0 : regs[rd];
  assign rs_val = (rs == 4'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 4'd0) ? '0 : regs[rt];

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ir[31:28]),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .imm    (imm),
    .result (alu_result),
    .taken  (taken)
  );

  assign ld_st_addr = ADDR_W'(rs_val) + ADDR_W'(imm);
  assign arg_addr   = args_start_i + (ADDR_W'(imm) << 2);
  assign acc_width  = width_norm(rt);

  always_comb begin
    case (acc_width)
      WIDTH_B: byte_mask = DATA_W'(8'hFF);
      WIDTH_H: byte_mask = DATA_W'(16'hFFFF);
      default: byte_mask = '1;
    endcase
  end

  always_comb begin
    next_pc = pc + ADDR_W'(4);
    wr_en   = 1'b0;
    wr_data = alu_result;
    case (op)
      OP_LI, OP_LUI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
        wr_en = 1'b1;
      OP_LD: begin
        wr_en   = 1'b1;
        wr_data = mem_data_i & byte_mask;
      end
      OP_ARG: begin
        wr_en   = 1'b1;
        wr_data = mem_data_i;
      end
      OP_BEQ, OP_BNE: begin
        // Branch offset is relative to the branch's own address.
        if (taken) next_pc = pc + (ADDR_W'($signed(imm)) << 2);
      end
      OP_JMP:  next_pc = start_addr_i + (ADDR_W'(imm) << 2);
      default: ;
    endcase
  end

  // Reads must be combinational in the same cycle, so the port is decoded from state and IR.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    if (state == S_FETCH) begin
      mem_ce_o    = 1'b1;
      mem_addr_o  = pc;
      mem_width_o = WIDTH_W;
    end else if (state == S_EXEC) begin
      case (op)
        OP_LD: begin
          mem_ce_o    = 1'b1;
          mem_addr_o  = ld_st_addr;
          mem_width_o = acc_width;
        end
        OP_ST: begin
          mem_ce_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = ld_st_addr;
          mem_width_o = acc_width;
          mem_data_o  = rd_val & byte_mask;
        end
        OP_ARG: begin
          mem_ce_o    = 1'b1;
          mem_addr_o  = arg_addr;
          mem_width_o = WIDTH_W;
        end
        default: ;
      endcase
    end
  end

`ifdef EXECUTOR_WATCHDOG_EN
  logic [9:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == S_IDLE && start_i) begin
      wd_cnt <= '0;
    end else if (state == S_EXEC) begin
      wd_cnt <= wd_cnt + 10'd1;
    end
  end

  assign wd_expire = (wd_cnt == '1);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      ready_o <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            pc    <= start_addr_i;
            state <= S_FETCH;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
          end
        end
        S_FETCH: begin
          ir    <= mem_data_i[31:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en && rd != 4'd0) regs[rd] <= wr_data;
          pc <= next_pc;
          if (op == OP_HALT || wd_expire) begin
            state   <= S_DONE;
            ready_o <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!start_i) begin
            state   <= S_IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_executor.sv
// Self-checking bench for packet_executor: directed programs plus random ALU/LD/ST programs
// checked against an instruction-level interpreter of the ISA.
module tb_packet_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] start_addr_i;
  logic [31:0] args_start_i;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        ready_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  packet_executor #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .args_start_i (args_start_i),
    .mem_ce_o     (mem_ce_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_width_o  (mem_width_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .ready_o      (ready_o)
  );

  // Little-endian byte memory acting as the sram bridge.
  always_comb begin
    mem_data_i = '0;
    if (mem_ce_o && !mem_we_o)
      for (int k = 0; k < 4; k++)
        if (k < int'(mem_width_o)) mem_data_i[8*k +: 8] = mem[12'(mem_addr_o + 32'(k))];
  end

  always @(posedge clk) begin
    if (mem_ce_o && mem_we_o)
      for (int k = 0; k < 4; k++)
        if (k < int'(mem_width_o)) mem[12'(mem_addr_o + 32'(k))] = mem_data_o[8*k +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int imm);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt), 16'(imm)};
  endfunction

  task automatic put8(input logic [31:0] a, input logic [7:0] v);
    mem[12'(a)]     = v;
    ref_mem[12'(a)] = v;
  endtask

  task automatic put32(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) put8(a + 32'(k), v[8*k +: 8]);
  endtask

  task automatic load_prog(input logic [31:0] base, input logic [31:0] prog[$]);
    foreach (prog[i]) put32(base + 32'(4 * i), prog[i]);
  endtask

  function automatic logic [31:0] dmem32(input logic [31:0] a);
    return {mem[12'(a + 3)], mem[12'(a + 2)], mem[12'(a + 1)], mem[12'(a)]};
  endfunction

  function automatic logic [31:0] rmem(input logic [31:0] a, input int w);
    logic [31:0] v = '0;
    for (int k = 0; k < w; k++) v[8*k +: 8] = ref_mem[12'(a + 32'(k))];
    return v;
  endfunction

  // ISA interpreter over ref_mem; returns the number of instructions executed.
  task automatic run_model(input logic [31:0] base, input logic [31:0] args, output int unsigned n);
    logic [31:0] r [16];
    logic [31:0] pc, ir, a, b, ea, npc, imm;
    int          op, rd, w;
    bit          halted = 0;
    for (int i = 0; i < 16; i++) r[i] = 0;
    pc = base;
    n  = 0;
    while (!halted && n < 5000) begin
      ir  = rmem(pc, 4);
      n++;
      op  = int'(ir[31:28]);
      rd  = int'(ir[27:24]);
      a   = r[ir[23:20]];
      b   = r[ir[19:16]];
      imm = {16'h0, ir[15:0]};
      w   = (ir[19:16] == 4'd1 || ir[19:16] == 4'd2) ? int'(ir[19:16]) : 4;
      ea  = a + imm;
      npc = pc + 4;
      case (op)
        0:  halted = 1;
        1:  r[rd] = imm;
        2:  r[rd] = imm * 65536;
        3:  r[rd] = a + b;
        4:  r[rd] = a - b;
        5:  r[rd] = a & b;
        6:  r[rd] = a | b;
        7:  r[rd] = a ^ b;
        8:  r[rd] = a << imm[4:0];
        9:  r[rd] = a >> imm[4:0];
        10: r[rd] = rmem(ea, w);
        11: for (int k = 0; k < w; k++) ref_mem[12'(ea + 32'(k))] = r[rd][8*k +: 8];
        12: r[rd] = rmem(args + 4 * imm, 4);
        13: if (a == b) npc = pc + 4 * {{16{imm[15]}}, imm[15:0]};
        14: if (a != b) npc = pc + 4 * {{16{imm[15]}}, imm[15:0]};
        default: npc = base + 4 * imm;
      endcase
      r[0] = 0;
      pc   = npc;
    end
  endtask

  // Start edge is the first posedge with start_i high; counts edges until ready_o.
  task automatic run_dut(input int unsigned limit, output int unsigned edges);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    edges = 0;
    while (edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) break;
    end
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check(tag, 32'(ready_o), 32'd0);
  endtask

  initial begin
    logic [31:0]  prog[$];
    int unsigned  n, edges;
    bit           saw_ready;

    rst          = 1'b1;
    start_i      = 1'b0;
    start_addr_i = '0;
    args_start_i = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_ce",    32'(mem_ce_o), 32'd0);
    check("rst_we",    32'(mem_we_o), 32'd0);
    check("rst_addr",  mem_addr_o, 32'd0);
    check("rst_width", 32'(mem_width_o), 32'd0);
    check("rst_data",  mem_data_o, 32'd0);

    // ALU program at 64.
    prog = {enc(1, 1, 0, 0, 5), enc(1, 2, 0, 0, 7), enc(3, 3, 1, 2, 0),
            enc(11, 3, 0, 4, 200), enc(0, 0, 0, 0, 0)};
    load_prog(64, prog);
    start_addr_i = 64;
    run_model(64, 0, n);
    run_dut(200, edges);
    check("alu_ready",  32'(ready_o), 32'd1);
    check("alu_cycles", edges, 32'd10);
    check("alu_model_cycles", edges, 2 * n);
    check("alu_mem200", dmem32(200), 32'd12);
    drop_start("alu_idle");

    // Packet load: 2-byte read at byte 1.
    put32(0, 32'h44332211);
    put32(204, 32'hA5A5A5A5);
    prog = {enc(10, 1, 0, 2, 1), enc(11, 1, 0, 4, 204), enc(0, 0, 0, 0, 0)};
    load_prog(300, prog);
    start_addr_i = 300;
    run_model(300, 0, n);
    run_dut(200, edges);
    check("ld_cycles", edges, 32'd6);
    check("ld_mem204", dmem32(204), 32'h00003322);
    check("ld_model",  dmem32(204), rmem(204, 4));
    drop_start("ld_idle");

    // Argument fetch.
    put32(136, 32'hDEADBEEF);
    prog = {enc(12, 4, 0, 0, 2), enc(11, 4, 0, 4, 208), enc(0, 0, 0, 0, 0)};
    load_prog(320, prog);
    start_addr_i = 320;
    args_start_i = 128;
    run_model(320, 128, n);
    run_dut(200, edges);
    check("arg_cycles", edges, 32'd6);
    check("arg_mem208", dmem32(208), 32'hDEADBEEF);
    drop_start("arg_idle");

    // Countdown loop with r0 write-ignore.
    put32(212, 32'h12345678);
    put32(216, 32'h9ABCDEF0);
    prog = {enc(1, 1, 0, 0, 3), enc(1, 5, 0, 0, 1), enc(1, 0, 0, 0, 16'h55),
            enc(4, 1, 1, 5, 0), enc(14, 0, 1, 0, -1),
            enc(11, 1, 0, 4, 212), enc(11, 0, 0, 4, 216), enc(0, 0, 0, 0, 0)};
    load_prog(340, prog);
    start_addr_i = 340;
    run_model(340, 0, n);
    run_dut(500, edges);
    check("loop_cycles", edges, 32'd24);
    check("loop_model_cycles", edges, 2 * n);
    check("loop_r1", dmem32(212), 32'd0);
    check("loop_r0", dmem32(216), 32'd0);
    drop_start("loop_idle");

    // Reset mid-program with start_i held, then a clean rerun.
    put32(212, 32'h12345678);
    put32(216, 32'h9ABCDEF0);
    @(negedge clk);
    start_i = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    check("mid_rst_ce",    32'(mem_ce_o), 32'd0);
    check("mid_rst_addr",  mem_addr_o, 32'd0);
    put32(212, 32'h12345678);
    run_dut(500, edges);
    check("rerun_cycles", edges, 32'd24);
    check("rerun_r1", dmem32(212), 32'd0);
    check("rerun_r0", dmem32(216), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_ready", 32'(ready_o), 32'd1);
    check("hold_no_access", 32'(mem_ce_o), 32'd0);
    drop_start("hold_idle");

    // Random ALU / load / store programs against the interpreter.
    for (int t = 0; t < 6; t++) begin
      for (int a = 400; a < 432; a++) put8(a, 8'($urandom));
      for (int a = 600; a < 700; a++) put8(a, 8'($urandom));
      prog = {};
      for (int i = 1; i < 8; i++)
        prog.push_back(enc(($urandom_range(0, 3) == 0) ? 2 : 1, i, 0, 0, int'($urandom_range(0, 65535))));
      for (int i = 0; i < 12; i++)
        prog.push_back(enc(int'($urandom_range(3, 9)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 65535))));
      for (int i = 0; i < 2; i++)
        prog.push_back(enc(10, int'($urandom_range(1, 7)), 0, int'($urandom_range(0, 15)),
                           int'($urandom_range(600, 690))));
      for (int i = 0; i < 8; i++)
        prog.push_back(enc(11, i, 0, int'($urandom_range(0, 15)), 400 + 4 * i));
      prog.push_back(enc(0, 0, 0, 0, 0));
      load_prog(1024, prog);
      start_addr_i = 1024;
      run_model(1024, 0, n);
      run_dut(500, edges);
      check($sformatf("rand%0d_cycles", t), edges, 2 * n);
      for (int i = 0; i < 8; i++)
        check($sformatf("rand%0d_word%0d", t, i), dmem32(400 + 4 * i), rmem(400 + 4 * i, 4));
      drop_start($sformatf("rand%0d_idle", t));
    end

    // Infinite loop: JMP 0.
    put32(2000, enc(15, 0, 0, 0, 0));
    start_addr_i = 2000;
`ifdef EXECUTOR_WATCHDOG_EN
    run_dut(2100, edges);
    check("wd_ready",  32'(ready_o), 32'd1);
    check("wd_cycles", edges, 32'd2048);
    repeat (2) @(posedge clk);
    #1;
    check("wd_no_access", 32'(mem_ce_o), 32'd0);
    drop_start("wd_idle");
`else
    saw_ready = 0;
    @(negedge clk);
    start_i = 1'b1;
    repeat (2100) begin
      @(posedge clk);
      #1;
      if (ready_o) saw_ready = 1;
    end
    check("nowd_ready", 32'(saw_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("nowd_rst_ce", 32'(mem_ce_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
